pipelined_divider_vr: RTL

- Parametrised pipelined integer divider with valid/ready handshake, signed/unsigned mode per operation and defined divide-by-zero results.
- Successor to the fixed 32-bit/8-stage restoring divider.
- Serves as the DIV/REM functional unit inside a CGRA tile.
- Accepts one operation per cycle and returns results in order, with a sideband tag.

---
 rtl/pipelined_divider_vr.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/pipelined_divider_vr.sv
// Pipelined restoring integer divider with valid/ready handshake.
// Signed or unsigned per operation, in-order results with a sideband tag,
// defined divide-by-zero results. Define DIVIDER_PERF_CNT_EN to add the
// perf_ops / perf_stall counters.
module pipelined_divider_vr #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 8,
  parameter int TAG_W  = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_signed,
  input  logic [WIDTH-1:0] in_dividend,
  input  logic [WIDTH-1:0] in_divisor,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_quotient,
  output logic [WIDTH-1:0] out_remainder,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_div_by_zero
`ifdef DIVIDER_PERF_CNT_EN
  ,
  output logic [31:0]      perf_ops,
  output logic [31:0]      perf_stall
`endif
);

  localparam int BASE_BITS = WIDTH / STAGES;
  localparam int LAST_BITS = BASE_BITS + (WIDTH % STAGES);
  localparam int NP        = (STAGES > 1) ? STAGES - 1 : 1;
  localparam int LS        = STAGES - 1;

  // Two's-complement negate when neg is set; used for operand magnitudes and result signs.
  function automatic logic [WIDTH-1:0] cond_negate(input logic [WIDTH-1:0] v, input logic neg);
    logic signed [WIDTH-1:0] sv;
    sv = v;
    return neg ? -sv : sv;
  endfunction

  logic advance;

  // Operand conditioning ahead of stage 0
  logic             sd, sv;
  logic [WIDTH-1:0] mag_dvd, mag_dvs;

  // Per-stage combinational results (index s = state after stage s)
  logic             valid_d [STAGES];
  logic [WIDTH:0]   rem_d   [STAGES];
  logic [WIDTH-1:0] qd_d    [STAGES];
  logic [WIDTH-1:0] dvs_d   [STAGES];
  logic [WIDTH-1:0] dvd_d   [STAGES];
  logic             qneg_d  [STAGES];
  logic             rneg_d  [STAGES];
  logic             dz_d    [STAGES];
  logic [TAG_W-1:0] tag_d   [STAGES];

  // Inter-stage registers; the last stage lands directly in the output registers
  logic             valid_q [NP];
  logic [WIDTH:0]   rem_q   [NP];
  logic [WIDTH-1:0] qd_q    [NP];
  logic [WIDTH-1:0] dvs_q   [NP];
  logic [WIDTH-1:0] dvd_q   [NP];
  logic             qneg_q  [NP];
  logic             rneg_q  [NP];
  logic             dz_q    [NP];
  logic [TAG_W-1:0] tag_q   [NP];

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_quotient_q, out_quotient_d;
  logic [WIDTH-1:0] out_remainder_q, out_remainder_d;
  logic [TAG_W-1:0] out_tag_q, out_tag_d;
  logic             out_div_by_zero_q, out_div_by_zero_d;

  assign advance  = !out_valid_q || out_ready;
  assign in_ready = advance;

  // Sign extraction and operand magnitudes
  always_comb begin
    sd      = in_signed & in_dividend[WIDTH-1];
    sv      = in_signed & in_divisor[WIDTH-1];
    mag_dvd = cond_negate(in_dividend, sd);
    mag_dvs = cond_negate(in_divisor, sv);
  end

  // Restoring division, MSB first: each stage consumes its share of dividend bits
  always_comb begin
    logic [WIDTH:0]   rem;
    logic [WIDTH-1:0] qd;
    int               prev;
    int               nb;
    for (int s = 0; s < STAGES; s++) begin
      prev = (s > 0) ? s - 1 : 0;
      if (s == 0) begin
        valid_d[s] = in_valid;
        rem        = '0;
        qd         = mag_dvd;
        dvs_d[s]   = mag_dvs;
        dvd_d[s]   = in_dividend;
        qneg_d[s]  = sd ^ sv;
        rneg_d[s]  = sd;
        dz_d[s]    = (in_divisor == '0);
        tag_d[s]   = in_tag;
      end else begin
        valid_d[s] = valid_q[prev];
        rem        = rem_q[prev];
        qd         = qd_q[prev];
        dvs_d[s]   = dvs_q[prev];
        dvd_d[s]   = dvd_q[prev];
        qneg_d[s]  = qneg_q[prev];
        rneg_d[s]  = rneg_q[prev];
        dz_d[s]    = dz_q[prev];
        tag_d[s]   = tag_q[prev];
      end
      nb = (s == STAGES - 1) ? LAST_BITS : BASE_BITS;
      for (int b = 0; b < WIDTH; b++) begin
        if (b < nb) begin
          rem = {rem[WIDTH-1:0], qd[WIDTH-1]};
          qd  = {qd[WIDTH-2:0], 1'b0};
          if (rem >= {1'b0, dvs_d[s]}) begin
            rem   = rem - {1'b0, dvs_d[s]};
            qd[0] = 1'b1;
          end
        end
      end
      rem_d[s] = rem;
      qd_d[s]  = qd;
    end
  end

  // Sign and divide-by-zero fixup on the last stage's result; hold while stalled
  always_comb begin
    out_valid_d       = out_valid_q;
    out_quotient_d    = out_quotient_q;
    out_remainder_d   = out_remainder_q;
    out_tag_d         = out_tag_q;
    out_div_by_zero_d = out_div_by_zero_q;
    if (advance) begin
      out_valid_d = valid_d[LS];
      if (valid_d[LS]) begin
        out_quotient_d    = dz_d[LS] ? '1 : cond_negate(qd_d[LS], qneg_d[LS]);
        out_remainder_d   = dz_d[LS] ? dvd_d[LS] : cond_negate(rem_d[LS][WIDTH-1:0], rneg_d[LS]);
        out_tag_d         = tag_d[LS];
        out_div_by_zero_d = dz_d[LS];
      end
    end
  end

  // Stage valid bits: cleared by reset so in-flight work is discarded
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s < NP; s++) valid_q[s] <= 1'b0;
    end else if (advance) begin
      for (int s = 0; s < STAGES - 1; s++) valid_q[s] <= valid_d[s];
    end
  end

  // Stage data registers shift with the valid bits
  always_ff @(posedge clk) begin
    if (advance) begin
      for (int s = 0; s < STAGES - 1; s++) begin
        rem_q[s]  <= rem_d[s];
        qd_q[s]   <= qd_d[s];
        dvs_q[s]  <= dvs_d[s];
        dvd_q[s]  <= dvd_d[s];
        qneg_q[s] <= qneg_d[s];
        rneg_q[s] <= rneg_d[s];
        dz_q[s]   <= dz_d[s];
        tag_q[s]  <= tag_d[s];
      end
    end
  end

  // Output registers, zeroed by reset
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q       <= 1'b0;
      out_quotient_q    <= '0;
      out_remainder_q   <= '0;
      out_tag_q         <= '0;
      out_div_by_zero_q <= 1'b0;
    end else begin
      out_valid_q       <= out_valid_d;
      out_quotient_q    <= out_quotient_d;
      out_remainder_q   <= out_remainder_d;
      out_tag_q         <= out_tag_d;
      out_div_by_zero_q <= out_div_by_zero_d;
    end
  end

  assign out_valid       = out_valid_q;
  assign out_quotient    = out_quotient_q;
  assign out_remainder   = out_remainder_q;
  assign out_tag         = out_tag_q;
  assign out_div_by_zero = out_div_by_zero_q;

`ifdef DIVIDER_PERF_CNT_EN
  logic [31:0] perf_ops_q, perf_ops_d;
  logic [31:0] perf_stall_q, perf_stall_d;

  // Completed-result and back-pressure cycle counts, wrapping naturally
  always_comb begin
    perf_ops_d   = perf_ops_q + ((out_valid_q && out_ready) ? 32'd1 : 32'd0);
    perf_stall_d = perf_stall_q + ((out_valid_q && !out_ready) ? 32'd1 : 32'd0);
  end

  // Counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_ops_q   <= '0;
      perf_stall_q <= '0;
    end else begin
      perf_ops_q   <= perf_ops_d;
      perf_stall_q <= perf_stall_d;
    end
  end

  assign perf_ops   = perf_ops_q;
  assign perf_stall = perf_stall_q;
`endif

endmodule
